// File: rtl/instr_fetch_unit_pkg.sv
// Shared encodings for the fetch stage: FSM states, the NOP filler word and
// the instruction field positions that Control_Unit decodes.
package instr_fetch_unit_pkg;

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Fetch buffer: DEPTH x WIDTH entries with push/pop/flush. Pointers carry one
// extra wrap bit so full and empty are told apart without a separate counter.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign w_do_push = i_push && !w_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an empty buffer is never read out by the top.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, runs the single-outstanding imem handshake and
// presents the buffered head instruction and its decode fields downstream.
//   state   | meaning
//   S_RESET | leaving reset, no request yet
//   S_FETCH | request may be issued when the buffer has a free slot
//   S_WAIT  | one live request outstanding, response will be buffered
//   S_DROP  | outstanding request was killed by a redirect, response discarded
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [31:0]     i_imem_rdata,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_inst_valid,
  input  logic            i_inst_ready,
  output logic [31:0]     o_inst_data,
  output logic [XLEN-1:0] o_inst_pc,
  output logic [6:0]      o_opcode,
  output logic [2:0]      o_funct3,
  output logic [6:0]      o_funct7,
  output logic            o_misalign_pulse
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 32 + XLEN;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_req_pc;
  logic            r_gap;
  logic            w_gap_nxt;
  logic            r_misalign;

  logic            w_req;
  logic            w_grant;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_count;
  logic            w_empty;
  logic [EW-1:0]   w_head;

  // The free-slot test plus the single-outstanding rule keeps a slot reserved
  // for every response that will be pushed.
  assign w_req   = (r_state == S_FETCH) && !r_gap && (w_count < CW'(FIFO_DEPTH));
  assign w_grant = w_req && i_imem_gnt;
  assign w_push  = (r_state == S_WAIT) && i_imem_rvalid && !i_redirect_valid;
  assign w_pop   = o_inst_valid && i_inst_ready && !i_redirect_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_gap_nxt   = 1'b0;
    case (r_state)
      S_RESET: w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (w_grant) begin
          w_state_nxt = S_WAIT;
          w_pc_nxt    = r_pc + XLEN'(4);
        end
      end
      S_WAIT, S_DROP: begin
        if (i_imem_rvalid) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_RESET;
    endcase

    // Redirect overrides everything; a request already granted becomes a drop.
    if (i_redirect_valid) begin
      w_pc_nxt = {i_redirect_pc[XLEN-1:2], 2'b00};
      case (r_state)
        S_RESET: w_state_nxt = S_FETCH;
        S_FETCH: begin
          w_state_nxt = w_grant ? S_DROP : S_FETCH;
          w_gap_nxt   = !w_grant;
        end
        default: w_state_nxt = i_imem_rvalid ? S_FETCH : S_DROP;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_RESET;
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_gap      <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_gap      <= w_gap_nxt;
      r_misalign <= i_redirect_valid && i_redirect_pc[1];
      if (w_grant) r_req_pc <= r_pc;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect_valid),
    .i_wdata ({r_req_pc, i_imem_rdata}),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign o_imem_req       = w_req;
  assign o_imem_addr      = r_pc;
  assign o_inst_valid     = !w_empty;
  assign o_inst_data      = w_empty ? INST_NOP : w_head[31:0];
  assign o_inst_pc        = w_empty ? '0 : w_head[EW-1:32];
  assign o_opcode         = o_inst_data[OPCODE_MSB:OPCODE_LSB];
  assign o_funct3         = o_inst_data[FUNCT3_MSB:FUNCT3_LSB];
  assign o_funct7         = o_inst_data[FUNCT7_MSB:FUNCT7_LSB];
  assign o_misalign_pulse = r_misalign;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based reference model checked every cycle
// plus directed scenarios with literal expectations; second instance covers PC wrap.
module tb_instr_fetch_unit;

  localparam int          DEPTH      = 2;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam int          OUT_NONE   = 0;
  localparam int          OUT_LIVE   = 1;
  localparam int          OUT_KILLED = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance A (RESET_PC = 0)
  logic        req, ivalid, mis;
  logic [31:0] addr, idata, ipc;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic        gnt = 1'b0, rvalid = 1'b0, redir = 1'b0, iready = 1'b0;
  logic [31:0] rdata = '0, redir_pc = '0;

  // instance B (RESET_PC = FFFF_FFFC)
  logic        b_req, b_valid, b_mis;
  logic [31:0] b_addr, b_data, b_pc;
  logic [6:0]  b_opc, b_f7;
  logic [2:0]  b_f3;
  logic        b_gnt = 1'b0, b_rvalid = 1'b0;
  logic [31:0] b_rdata = '0;

  int n_vec  = 0;
  int n_miss = 0;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_gnt(gnt), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .i_redirect_valid(redir), .i_redirect_pc(redir_pc),
    .o_inst_valid(ivalid), .i_inst_ready(iready), .o_inst_data(idata),
    .o_inst_pc(ipc), .o_opcode(opc), .o_funct3(f3), .o_funct7(f7),
    .o_misalign_pulse(mis));

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .i_clk(clk), .i_rst(rst), .o_imem_req(b_req), .o_imem_addr(b_addr),
    .i_imem_gnt(b_gnt), .i_imem_rvalid(b_rvalid), .i_imem_rdata(b_rdata),
    .i_redirect_valid(1'b0), .i_redirect_pc(32'h0),
    .o_inst_valid(b_valid), .i_inst_ready(1'b1), .o_inst_data(b_data),
    .o_inst_pc(b_pc), .o_opcode(b_opc), .o_funct3(b_f3), .o_funct7(b_f7),
    .o_misalign_pulse(b_mis));

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[11:2], 22'h0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  // memory responders: rvalid rv_delay cycles after the grant cycle
  int          rv_delay = 1;
  logic        pend = 1'b0, b_pend = 1'b0;
  int          pcnt = 0;
  logic [31:0] paddr = '0, b_paddr = '0;
  logic [31:0] acc_log[$], accb_log[$], popa_log[$], popb_log[$];

  always begin
    @(posedge clk); #1;
    rvalid = 1'b0;
    if (pend) begin
      if (pcnt <= 1) begin
        rvalid = 1'b1; rdata = word(paddr); pend = 1'b0;
      end else pcnt--;
    end
    if (req && gnt) begin
      pend = 1'b1; pcnt = rv_delay; paddr = addr; acc_log.push_back(addr);
    end
  end

  always begin
    @(posedge clk); #1;
    b_rvalid = 1'b0;
    if (b_pend) begin
      b_rvalid = 1'b1; b_rdata = word(b_paddr); b_pend = 1'b0;
    end
    if (b_req && b_gnt) begin
      b_pend = 1'b1; b_paddr = b_addr; accb_log.push_back(b_addr);
    end
  end

  always @(negedge clk) begin
    if (!rst && ivalid && iready && !redir) popa_log.push_back(ipc);
    if (!rst && b_valid) popb_log.push_back(b_pc);
  end

  // reference model for instance A
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  ent_t        m_ent;
  logic        m_started, m_gap, m_mis, m_acc, m_resp, m_pop;
  int          m_out;
  logic [31:0] m_pc, m_req_pc;

  function automatic logic m_req();
    return m_started && (m_out == OUT_NONE) && !m_gap && (mq.size() < DEPTH);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_pc = 32'h0; m_req_pc = 32'h0; m_started = 1'b0;
      m_gap = 1'b0; m_mis = 1'b0; m_out = OUT_NONE;
    end else begin
      m_acc  = m_req() && gnt;
      m_resp = rvalid && (m_out != OUT_NONE);
      m_pop  = (mq.size() != 0) && iready;
      m_mis  = redir && redir_pc[1];
      m_gap  = 1'b0;
      if (redir) begin
        mq.delete();
        if (!m_started) m_started = 1'b1;
        else if (m_out == OUT_NONE) begin
          if (m_acc) m_out = OUT_KILLED;
          else m_gap = 1'b1;
        end else m_out = m_resp ? OUT_NONE : OUT_KILLED;
        m_pc = {redir_pc[31:2], 2'b00};
      end else begin
        if (m_pop) mq.delete(0);
        if (!m_started) m_started = 1'b1;
        else if (m_acc) begin
          m_out = OUT_LIVE; m_req_pc = m_pc; m_pc = m_pc + 32'd4;
        end else if (m_resp) begin
          if (m_out == OUT_LIVE) begin
            m_ent.pc = m_req_pc; m_ent.data = rdata; mq.push_back(m_ent);
          end
          m_out = OUT_NONE;
        end
      end
    end
  end

  logic [31:0] e_data, e_pc;
  always @(negedge clk) begin
    e_data = NOP;
    e_pc   = 32'h0;
    if (mq.size() != 0) begin
      e_data = mq[0].data;
      e_pc   = mq[0].pc;
    end
    check("req",      32'(req),    32'(m_req()));
    check("addr",     addr,        m_pc);
    check("valid",    32'(ivalid), 32'(mq.size() != 0));
    check("data",     idata,       e_data);
    check("pc",       ipc,         e_pc);
    check("opcode",   32'(opc),    32'(e_data[6:0]));
    check("funct3",   32'(f3),     32'(e_data[14:12]));
    check("funct7",   32'(f7),     32'(e_data[31:25]));
    check("misalign", 32'(mis),    32'(m_mis));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // leaves rst low just after a rising edge; the next edge leaves S_RESET
  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b1; redir = 1'b0;
    tick(4);
    acc_log.delete(); accb_log.delete(); popa_log.delete(); popb_log.delete();
    rst = 1'b0;
  endtask

  initial begin
    gnt = 1'b1; b_gnt = 1'b1;
    tick(2);
    check("rst_req",   32'(req),    32'h0);
    check("rst_valid", 32'(ivalid), 32'h0);
    check("rst_data",  idata,       NOP);
    check("rst_addr",  addr,        32'h0);
    check("rst_pc",    ipc,         32'h0);
    check("rst_mis",   32'(mis),    32'h0);
    check("rst_baddr", b_addr,      32'hFFFF_FFFC);

    // straight-line fetch, min latency, and wrap on instance B
    iready = 1'b1;
    acc_log.delete(); accb_log.delete(); popa_log.delete(); popb_log.delete();
    rst = 1'b0;
    tick(1);
    check("t1_req",    32'(req),    32'h1);
    check("t1_addr0",  addr,        32'h0);
    tick(1);
    check("t1_wait",   32'(ivalid), 32'h0);
    tick(1);
    check("t1_valid",  32'(ivalid), 32'h1);
    check("t1_pc",     ipc,         32'h0);
    check("t1_data",   idata,       32'h0050_0093);
    check("t1_opc",    32'(opc),    32'h13);
    tick(8);
    check("t1_acc0",   qget(acc_log, 0),  32'h0);
    check("t1_acc1",   qget(acc_log, 1),  32'h4);
    check("t1_acc2",   qget(acc_log, 2),  32'h8);
    check("t5_acc0",   qget(accb_log, 0), 32'hFFFF_FFFC);
    check("t5_acc1",   qget(accb_log, 1), 32'h0);
    check("t5_pop0",   qget(popb_log, 0), 32'hFFFF_FFFC);
    check("t5_pop1",   qget(popb_log, 1), 32'h0);

    // decode stalled: buffer fills with two words then requests stop
    iready = 1'b0;
    do_reset();
    tick(12);
    check("t2_nacc",   32'(acc_log.size()), 32'd2);
    check("t2_req",    32'(req),    32'h0);
    check("t2_valid",  32'(ivalid), 32'h1);
    check("t2_pc",     ipc,         32'h0);
    iready = 1'b1;
    tick(6);
    check("t2_pop0",   qget(popa_log, 0), 32'h0);
    check("t2_pop1",   qget(popa_log, 1), 32'h4);
    check("t2_acc2",   qget(acc_log, 2),  32'h8);

    // redirect while a request is outstanding
    rv_delay = 3;
    do_reset();
    tick(2);
    check("t3_wait",   32'(req),    32'h0);
    redir = 1'b1; redir_pc = 32'h100;
    tick(1);
    redir = 1'b0;
    check("t3_req",    32'(req),    32'h0);
    check("t3_addr",   addr,        32'h100);
    for (int i = 0; i < 20 && !ivalid; i++) tick(1);
    check("t3_valid",  32'(ivalid), 32'h1);
    check("t3_pc",     ipc,         32'h100);
    check("t3_acc1",   qget(acc_log, 1), 32'h100);

    // redirect coinciding with rvalid and pop, misaligned target
    rv_delay = 1;
    iready = 1'b0;
    do_reset();
    tick(4);
    check("t4_valid",  32'(ivalid), 32'h1);
    check("t4_pc",     ipc,         32'h0);
    iready = 1'b1; redir = 1'b1; redir_pc = 32'h202;
    tick(1);
    redir = 1'b0;
    check("t4_flush",  32'(ivalid), 32'h0);
    check("t4_mis",    32'(mis),    32'h1);
    check("t4_req",    32'(req),    32'h1);
    check("t4_addr",   addr,        32'h200);
    tick(1);
    check("t4_mis_end", 32'(mis),   32'h0);
    check("t4_acc",    qget(acc_log, 2), 32'h200);

    // reset while waiting; the late response must be ignored
    rv_delay = 3;
    do_reset();
    tick(2);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("t6_valid_a", 32'(ivalid), 32'h0);
    check("t6_addr_a",  addr,        32'h0);
    tick(1);
    check("t6_valid_b", 32'(ivalid), 32'h0);
    rst = 1'b0;
    tick(1);
    check("t6_req",    32'(req),    32'h1);
    check("t6_addr",   addr,        32'h0);
    check("t6_valid_c", 32'(ivalid), 32'h0);
    for (int i = 0; i < 20 && !ivalid; i++) tick(1);
    check("t6_valid",  32'(ivalid), 32'h1);
    check("t6_pc",     ipc,         32'h0);
    check("t6_data",   idata,       32'h0050_0093);
    check("t6_acc1",   qget(acc_log, 1), 32'h0);

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
